// File: rtl/psum_deskew_buffer.sv
// psum_deskew_buffer
// Captures the diagonally skewed C_out stream of the PE array (column c lags
// column 0 by c beats), stores it as a ROWS x COLS partial-sum tile, serves the
// tile row-by-row on a valid/ready port, and can regenerate the skewed stream
// so a later K-pass can accumulate on top of it through C_acc.
module psum_deskew_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [COLS*2*DATA_WIDTH-1:0]  in_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [COLS*2*DATA_WIDTH-1:0]  rd_data,
  output logic [$clog2(ROWS)-1:0]       rd_row,
  output logic                          rd_last,
  input  logic                          replay_start,
  output logic                          replay_valid,
  output logic [COLS*2*DATA_WIDTH-1:0]  replay_data,
  output logic                          busy,
  output logic                          tile_done,
  output logic                          short_err,
  output logic                          ovf_err
);

  localparam int LW = 2 * DATA_WIDTH;
  localparam int N  = ROWS + COLS - 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FULL,
    REPLAY
  } state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   replay_cnt;
  logic [LW-1:0]   tile_buf [ROWS][COLS];
  logic [CW-1:0]   wr_beat;
  logic            capture_en;

  // The first beat of a tile arrives while still in IDLE, so it is always beat 0.
  always_comb begin
    wr_beat    = (state == IDLE) ? '0 : beat_cnt;
    capture_en = in_valid && ((state == IDLE) || (state == CAPTURE));
  end

  // Control FSM, counters, sticky flags and the tile storage itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      replay_cnt <= '0;
      rd_row     <= '0;
      tile_done  <= 1'b0;
      short_err  <= 1'b0;
      ovf_err    <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          tile_buf[r][c] <= '0;
        end
      end
    end else if (clr) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      replay_cnt <= '0;
      rd_row     <= '0;
      tile_done  <= 1'b0;
      short_err  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      tile_done <= 1'b0;

      if (capture_en) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (r + c == int'(wr_beat)) begin
              tile_buf[r][c] <= in_data[c*LW +: LW];
            end
          end
        end
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CAPTURE;
            beat_cnt <= CW'(1);
          end
        end

        CAPTURE: begin
          if (in_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              state     <= FULL;
              beat_cnt  <= '0;
              tile_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else begin
            short_err <= 1'b1;
            state     <= IDLE;
            beat_cnt  <= '0;
          end
        end

        FULL: begin
          if (in_valid) begin
            ovf_err <= 1'b1;
          end
          if (replay_start) begin
            if (rd_row == '0) begin
              state      <= REPLAY;
              replay_cnt <= '0;
            end
          end else if (rd_ready) begin
            if (rd_row == LAST_ROW) begin
              state  <= IDLE;
              rd_row <= '0;
            end else begin
              rd_row <= rd_row + 1'b1;
            end
          end
        end

        REPLAY: begin
          if (in_valid) begin
            ovf_err <= 1'b1;
          end
          if (replay_cnt == LAST_BEAT) begin
            state      <= FULL;
            replay_cnt <= '0;
          end else begin
            replay_cnt <= replay_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Read and replay ports are decoded straight from the stored tile; a replay
  // request in FULL withholds the read so the two never both happen.
  always_comb begin
    busy         = (state != IDLE);
    rd_valid     = (state == FULL) && !replay_start;
    rd_last      = rd_valid && (rd_row == LAST_ROW);
    replay_valid = (state == REPLAY);
    rd_data      = '0;
    replay_data  = '0;
    if (state == FULL) begin
      for (int c = 0; c < COLS; c++) begin
        rd_data[c*LW +: LW] = tile_buf[rd_row][c];
      end
    end
    if (state == REPLAY) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (r + c == int'(replay_cnt)) begin
            replay_data[c*LW +: LW] = tile_buf[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_deskew_buffer.sv
// tb_psum_deskew_buffer
// Drives skewed tiles built from V(r,c) = base + 16r + c + 1 into the deskew
// buffer and checks the drained rows and replayed beats against queues of
// expected words filled in as the stimulus is generated.
module tb_psum_deskew_buffer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int N  = R + C - 1;
  localparam int LW = 2 * W;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic [C*LW-1:0]   in_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [C*LW-1:0]   rd_data;
  logic [1:0]        rd_row;
  logic              rd_last;
  logic              replay_start;
  logic              replay_valid;
  logic [C*LW-1:0]   replay_data;
  logic              busy;
  logic              tile_done;
  logic              short_err;
  logic              ovf_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [C*LW-1:0] row_q[$];
  logic [C*LW-1:0] replay_q[$];

  typedef struct {
    logic [15:0]     base;
    bit              toggle;
    bit              replay;
    int              exp_xfers;
    logic [C*LW-1:0] exp_row3;
    logic [C*LW-1:0] exp_beat3;
  } vec_t;

  vec_t vecs[4];

  psum_deskew_buffer #(.DATA_WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_row       (rd_row),
    .rd_last      (rd_last),
    .replay_start (replay_start),
    .replay_valid (replay_valid),
    .replay_data  (replay_data),
    .busy         (busy),
    .tile_done    (tile_done),
    .short_err    (short_err),
    .ovf_err      (ovf_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] vval(logic [15:0] base, int r, int c);
    return base + 16'(16 * r + c + 1);
  endfunction

  function automatic logic [C*LW-1:0] make_beat(logic [15:0] base, int n);
    logic [C*LW-1:0] w;
    w = '0;
    for (int c = 0; c < C; c++) begin
      if ((n - c >= 0) && (n - c < R)) w[c*LW +: LW] = vval(base, n - c, c);
    end
    return w;
  endfunction

  function automatic logic [C*LW-1:0] make_row(logic [15:0] base, int r);
    logic [C*LW-1:0] w;
    for (int c = 0; c < C; c++) w[c*LW +: LW] = vval(base, r, c);
    return w;
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs();
    check_output("rst rd_valid", rd_valid, 0);
    check_output("rst rd_data", rd_data, 0);
    check_output("rst rd_row", rd_row, 0);
    check_output("rst rd_last", rd_last, 0);
    check_output("rst replay_valid", replay_valid, 0);
    check_output("rst replay_data", replay_data, 0);
    check_output("rst busy", busy, 0);
    check_output("rst tile_done", tile_done, 0);
    check_output("rst short_err", short_err, 0);
    check_output("rst ovf_err", ovf_err, 0);
  endtask

  // Sends all N skewed beats of one tile and queues its rows for the drain.
  task automatic apply_stimulus(logic [15:0] base);
    for (int n = 0; n < N; n++) begin
      in_valid = 1'b1;
      in_data  = make_beat(base, n);
      tick();
      if (n < N - 1) check_output("tile_done early", tile_done, 0);
      else           check_output("tile_done after last beat", tile_done, 1);
    end
    in_valid = 1'b0;
    in_data  = '0;
    for (int r = 0; r < R; r++) row_q.push_back(make_row(base, r));
    tick();
    check_output("tile_done single pulse", tile_done, 0);
    check_output("rd_valid when full", rd_valid, 1);
  endtask

  // Drains queued rows, optionally toggling rd_ready, checking order and hold.
  task automatic drain(bit toggle, int exp_xfers, logic [C*LW-1:0] exp_last);
    int xfers = 0;
    int cyc   = 0;
    int idx;
    bit holding = 0;
    logic [C*LW-1:0] held = '0;
    logic [C*LW-1:0] last_row = '0;
    while (row_q.size() > 0 && cyc < 40) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (rd_valid) begin
        if (holding) check_output("row held stable", rd_data, held);
        if (rd_ready) begin
          check_output("row data", rd_data, row_q.pop_front());
          idx = R - 1 - row_q.size();
          check_output("row index", rd_row, idx);
          check_output("rd_last", rd_last, idx == R - 1);
          last_row = rd_data;
          holding  = 0;
          xfers++;
        end else begin
          held    = rd_data;
          holding = 1;
        end
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    check_output("drain within budget", row_q.size(), 0);
    check_output("transfer count", xfers, exp_xfers);
    check_output("last row data", last_row, exp_last);
    check_output("busy after last row", busy, 0);
  endtask

  // Pulses replay_start at rd_row 0 and checks the regenerated skewed stream.
  task automatic do_replay(logic [15:0] base, bit with_ready, bit chk_b3,
                           logic [C*LW-1:0] exp_beat3);
    int count = 0;
    int cyc   = 0;
    for (int m = 0; m < N; m++) replay_q.push_back(make_beat(base, m));
    replay_start = 1'b1;
    rd_ready     = with_ready;
    #1;
    check_output("rd_valid masked by replay_start", rd_valid, 0);
    tick();
    replay_start = 1'b0;
    rd_ready     = 1'b0;
    if (with_ready) check_output("replay beats read, rd_row", rd_row, 0);
    while (cyc < 20 && (replay_valid || count == 0)) begin
      if (replay_valid) begin
        if (replay_q.size() > 0) check_output("replay beat", replay_data, replay_q.pop_front());
        if (chk_b3 && count == 3) check_output("replay beat 3", replay_data, exp_beat3);
        count++;
      end
      tick();
      cyc++;
    end
    replay_q.delete();
    check_output("replay beat count", count, N);
    check_output("back in FULL rd_valid", rd_valid, 1);
    check_output("back in FULL rd_row", rd_row, 0);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 1'b0, 1'b0, 4, 64'h0034_0033_0032_0031, 64'h0};
    vecs[1] = '{16'h0100, 1'b1, 1'b0, 4, 64'h0134_0133_0132_0131, 64'h0};
    vecs[2] = '{16'h0000, 1'b0, 1'b1, 4, 64'h0034_0033_0032_0031, 64'h0004_0013_0022_0031};
    vecs[3] = '{16'h8000, 1'b1, 1'b1, 4, 64'h8034_8033_8032_8031, 64'h8004_8013_8022_8031};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_ready = 1'b0; replay_start = 1'b0;
    tick();
    tick();
    check_idle_outputs();
    rst = 1'b0;
    tick();

    // Table-driven tiles: capture, optional replay, drain with or without backpressure.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].base);
      if (vecs[i].replay) begin
        do_replay(vecs[i].base, 1'b0, 1'b1, vecs[i].exp_beat3);
        if (vecs[i].base == 16'h0000) begin
          check_output("replay beat 0 const", make_beat(16'h0, 0), 64'h0000_0000_0000_0001);
        end
      end
      drain(vecs[i].toggle, vecs[i].exp_xfers, vecs[i].exp_row3);
    end

    // Short capture: three beats then in_valid drops.
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_data  = make_beat(16'h0300, n);
      tick();
      check_output("short tile_done", tile_done, 0);
    end
    in_valid = 1'b0;
    tick();
    check_output("short_err set", short_err, 1);
    check_output("short busy", busy, 0);
    check_output("short no tile_done", tile_done, 0);
    apply_stimulus(16'h0400);
    drain(1'b0, 4, make_row(16'h0400, 3));

    // Replay beats read, overflow, ignored replay after a row was taken.
    apply_stimulus(16'h0500);
    do_replay(16'h0500, 1'b1, 1'b0, '0);
    in_valid = 1'b1;
    in_data  = '1;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check_output("ovf_err set", ovf_err, 1);
    check_output("ovf busy", busy, 1);
    rd_ready = 1'b1;
    #1;
    check_output("row0 valid", rd_valid, 1);
    check_output("row0 after ovf", rd_data, row_q.pop_front());
    tick();
    rd_ready = 1'b0;
    check_output("rd_row after one read", rd_row, 1);
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    check_output("late replay ignored", replay_valid, 0);
    check_output("late replay rd_row", rd_row, 1);
    drain(1'b0, 3, make_row(16'h0500, 3));

    // Clear during replay beat 2, then clr against in_valid in IDLE.
    apply_stimulus(16'h0600);
    row_q.delete();
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    tick();
    tick();
    check_output("replay beat 2 before clr", replay_data, make_beat(16'h0600, 2));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_output("clr replay_valid", replay_valid, 0);
    check_output("clr busy", busy, 0);
    check_output("clr rd_valid", rd_valid, 0);
    check_output("clr short_err", short_err, 0);
    check_output("clr ovf_err", ovf_err, 0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = make_beat(16'h0700, 0);
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check_output("clr beats in_valid", busy, 0);
    apply_stimulus(16'h0700);
    drain(1'b1, 4, make_row(16'h0700, 3));

    // Reset from FULL returns every output to zero.
    apply_stimulus(16'h0800);
    row_q.delete();
    rst = 1'b1;
    tick();
    check_idle_outputs();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
